fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-aware round-robin arbiter for the write side of one FIFO.
// Grants one requester at a time and holds the grant until that requester's last beat
// transfers, so packets never interleave inside the FIFO.
//
// Optional build macro: SOURCE_TAG_EN -- when defined, fifo_data carries the grant index
// in its MSBs ({grant_id, payload}) and is WIDTH+ID_WIDTH bits wide.
//
// Ports:
//   clk              in   write-domain clock
//   rstn             in   synchronous active-low reset
//   req_valid        in   [NUM_REQ]        per-requester beat valid
//   req_last         in   [NUM_REQ]        per-requester last beat of packet
//   req_data         in   [NUM_REQ*WIDTH]  flattened payloads, requester i at [i*WIDTH +: WIDTH]
//   req_ready        out  [NUM_REQ]        per-requester beat accepted this cycle
//   fifo_write_ready in   FIFO not full
//   fifo_write_en    out  FIFO write strobe
//   fifo_data        out  FIFO write data
//   busy             out  a grant is held
//   grant_id         out  [ID_WIDTH]       current or last granted requester
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  localparam int unsigned ID_WIDTH = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
`ifdef SOURCE_TAG_EN
  localparam int unsigned OUT_WIDTH = WIDTH + ID_WIDTH
`else
  localparam int unsigned OUT_WIDTH = WIDTH
`endif
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_write_ready,
  output logic                       fifo_write_en,
  output logic [OUT_WIDTH-1:0]       fifo_data,
  output logic                       busy,
  output logic [ID_WIDTH-1:0]        grant_id
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_id;
  logic [ID_WIDTH-1:0] cand;
  logic                beat_xfer;
  logic [WIDTH-1:0]    sel_data;
  logic [WIDTH-1:0]    data_arr [NUM_REQ];

  // Increment modulo NUM_REQ; NUM_REQ need not be a power of two.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] id);
    return (id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  assign sel_data = data_arr[grant_id_q];

  // Round-robin search: first valid index starting at rr_ptr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_id_q;
    cand       = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    req_ready     = '0;
    fifo_write_en = 1'b0;
    beat_xfer     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_id_d = pick_id;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        // Ready follows FIFO space even during a valid bubble; grant is kept either way.
        req_ready[grant_id_q] = fifo_write_ready;
        beat_xfer             = req_valid[grant_id_q] & fifo_write_ready;
        fifo_write_en         = beat_xfer;
        if (beat_xfer && req_last[grant_id_q]) begin
          state_d  = StIdle;
          rr_ptr_d = wrap_inc(grant_id_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign grant_id = grant_id_q;

  // Zero while idle so the bus reads 0 after reset until the first grant.
`ifdef SOURCE_TAG_EN
  assign fifo_data = busy ? {grant_id_q, sel_data} : '0;
`else
  assign fifo_data = busy ? sel_data : '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed scenarios plus a randomized run checked
// against a packet-level reference model of the arbitration rules.
module tb_fifo_write_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
`ifdef SOURCE_TAG_EN
  localparam int DW = W + IDW;
`else
  localparam int DW = W;
`endif

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_write_ready = 1'b1;
  logic           fifo_write_en;
  logic [DW-1:0]  fifo_data;
  logic           busy;
  logic [IDW-1:0] grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_write_ready (fifo_write_ready),
    .fifo_write_en    (fifo_write_en),
    .fifo_data        (fifo_data),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_word(input int id, input logic [W-1:0] d);
`ifdef SOURCE_TAG_EN
    return {IDW'(id), d};
`else
    return DW'(d + 8'(id * 0));
`endif
  endfunction

  task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
    req_valid[i]       = v;
    req_last[i]        = l;
    req_data[i*W +: W] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_write_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = '0; req_last = '0; fifo_write_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({busy, grant_id, fifo_write_en, req_ready} !== '0 || fifo_data !== '0) begin
        n_fail++;
        $display("FAIL reset_idle c%0d busy/gid/wen/rdy got %b data %h want all zero",
                 c, {busy, grant_id, fifo_write_en, req_ready}, fifo_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_packet();
    bit         e_b [9] = '{0, 1, 1, 1, 0, 0, 1, 0, 1};
    logic [1:0] e_g [9] = '{0, 2, 2, 2, 2, 2, 3, 3, 0};
    bit         e_w [9] = '{0, 1, 1, 1, 0, 0, 1, 0, 1};
    logic [7:0] e_d [9] = '{0, 8'h11, 8'h22, 8'h33, 0, 0, 8'h3C, 0, 8'h0C};
    bit granted = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_valid = '0; req_last = '0; fifo_write_ready = 1'b1;
      case (c)
        0, 1: set_req(2, 1, 0, 8'h11);
        2:    set_req(2, 1, 0, 8'h22);
        3:    set_req(2, 1, 1, 8'h33);
        5, 6: begin set_req(0, 1, 1, 8'h0C); set_req(3, 1, 1, 8'h3C); end
        7, 8: set_req(0, 1, 1, 8'h0C);
        default: ;
      endcase
      #1;
      n_checks++;
      if ({busy, grant_id, fifo_write_en} !== {e_b[c], e_g[c], e_w[c]}) begin
        n_fail++;
        $display("FAIL single c%0d busy/gid/wen got %b want %b", c,
                 {busy, grant_id, fifo_write_en}, {e_b[c], e_g[c], e_w[c]});
      end
      n_checks++;
      if (req_ready !== (e_b[c] ? (N'(fifo_write_ready) << e_g[c]) : N'(0))) begin
        n_fail++;
        $display("FAIL single_ready c%0d got %b", c, req_ready);
      end
      if (e_w[c]) begin
        n_checks++;
        if (fifo_data !== exp_word(e_g[c], e_d[c])) begin
          n_fail++;
          $display("FAIL single_data c%0d got %h want %h", c, fifo_data, exp_word(e_g[c], e_d[c]));
        end
      end else if (!granted) begin
        n_checks++;
        if (fifo_data !== '0) begin
          n_fail++;
          $display("FAIL single_zero c%0d got %h want 0", c, fifo_data);
        end
      end
      if (e_b[c]) granted = 1;
    end
  endtask

  task automatic test_round_robin();
    int gid;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fifo_write_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1, 1, 8'(8'hA0 + i));
      gid = (c == 0) ? 0 : (((c - 1) / 2) % N);
      #1;
      n_checks++;
      if ({busy, grant_id, fifo_write_en} !== {c[0], IDW'(gid), c[0]}) begin
        n_fail++;
        $display("FAIL rr c%0d busy/gid/wen got %b want %b", c,
                 {busy, grant_id, fifo_write_en}, {c[0], IDW'(gid), c[0]});
      end
      if (c[0]) begin
        n_checks++;
        if (fifo_data !== exp_word(gid, 8'(8'hA0 + gid))) begin
          n_fail++;
          $display("FAIL rr_data c%0d got %h want %h", c, fifo_data, exp_word(gid, 8'(8'hA0 + gid)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit         e_b [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [1:0] e_g [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit         e_w [10] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
    logic [7:0] e_d [10] = '{0, 8'hB0, 8'hB1, 0, 0, 0, 8'hB2, 8'hB3, 0, 8'h0F};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = '0; req_last = '0; fifo_write_ready = 1'b1;
      case (c)
        0, 1:    set_req(1, 1, 0, 8'hB0);
        2:       set_req(1, 1, 0, 8'hB1);
        3, 4, 5: begin set_req(1, 1, 0, 8'hB2); set_req(0, 1, 1, 8'h0F); fifo_write_ready = 0; end
        6:       begin set_req(1, 1, 0, 8'hB2); set_req(0, 1, 1, 8'h0F); end
        7:       begin set_req(1, 1, 1, 8'hB3); set_req(0, 1, 1, 8'h0F); end
        default: set_req(0, 1, 1, 8'h0F);
      endcase
      #1;
      n_checks++;
      if ({busy, grant_id, fifo_write_en} !== {e_b[c], e_g[c], e_w[c]}) begin
        n_fail++;
        $display("FAIL backpressure c%0d busy/gid/wen got %b want %b", c,
                 {busy, grant_id, fifo_write_en}, {e_b[c], e_g[c], e_w[c]});
      end
      n_checks++;
      if (req_ready !== (e_b[c] ? (N'(fifo_write_ready) << e_g[c]) : N'(0))) begin
        n_fail++;
        $display("FAIL backpressure_ready c%0d got %b", c, req_ready);
      end
      if (e_w[c]) begin
        n_checks++;
        if (fifo_data !== exp_word(e_g[c], e_d[c])) begin
          n_fail++;
          $display("FAIL backpressure_data c%0d got %h want %h", c, fifo_data,
                   exp_word(e_g[c], e_d[c]));
        end
      end
    end
  endtask

  task automatic test_gap_wrap();
    bit         e_b [8] = '{0, 1, 1, 1, 1, 1, 0, 1};
    logic [1:0] e_g [8] = '{0, 3, 3, 3, 3, 3, 3, 0};
    bit         e_w [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    logic [7:0] e_d [8] = '{0, 8'hC0, 0, 0, 8'hC1, 8'hC2, 0, 8'hD0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = '0; req_last = '0; fifo_write_ready = 1'b1;
      case (c)
        0, 1:    set_req(3, 1, 0, 8'hC0);
        4:       begin set_req(3, 1, 0, 8'hC1); set_req(0, 1, 1, 8'hD0); end
        5:       begin set_req(3, 1, 1, 8'hC2); set_req(0, 1, 1, 8'hD0); end
        default: set_req(0, 1, 1, 8'hD0);
      endcase
      #1;
      n_checks++;
      if ({busy, grant_id, fifo_write_en} !== {e_b[c], e_g[c], e_w[c]}) begin
        n_fail++;
        $display("FAIL gap_wrap c%0d busy/gid/wen got %b want %b", c,
                 {busy, grant_id, fifo_write_en}, {e_b[c], e_g[c], e_w[c]});
      end
      n_checks++;
      if (req_ready !== (e_b[c] ? (N'(fifo_write_ready) << e_g[c]) : N'(0))) begin
        n_fail++;
        $display("FAIL gap_wrap_ready c%0d got %b", c, req_ready);
      end
      if (e_w[c]) begin
        n_checks++;
        if (fifo_data !== exp_word(e_g[c], e_d[c])) begin
          n_fail++;
          $display("FAIL gap_wrap_data c%0d got %h want %h", c, fifo_data, exp_word(e_g[c], e_d[c]));
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit         e_b [5] = '{0, 1, 1, 0, 0};
    logic [1:0] e_g [5] = '{0, 2, 2, 0, 0};
    bit         e_w [5] = '{0, 1, 1, 0, 0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = '0; req_last = '0; fifo_write_ready = 1'b1;
      rstn = !(c == 2 || c == 3);
      if (c < 4) set_req(2, 1, 0, 8'h5A);
      #1;
      n_checks++;
      if ({busy, grant_id, fifo_write_en} !== {e_b[c], e_g[c], e_w[c]}) begin
        n_fail++;
        $display("FAIL reset_mid c%0d busy/gid/wen got %b want %b", c,
                 {busy, grant_id, fifo_write_en}, {e_b[c], e_g[c], e_w[c]});
      end
      n_checks++;
      if (fifo_data !== (e_w[c] ? exp_word(2, 8'h5A) : DW'(0))) begin
        n_fail++;
        $display("FAIL reset_mid_data c%0d got %b", c, fifo_data);
      end
    end
  endtask

  task automatic test_random();
    bit             m_busy;
    int             m_owner, m_rr, j;
    bit             found;
    int             rem [N];
    logic [W-1:0]   bd [N];
    bit             pres [N];
    logic [N-1:0]   e_rdy;
    bit             e_wen;
    logic [DW-1:0]  e_dat;
    do_reset();
    m_busy = 0; m_owner = 0; m_rr = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = $urandom_range(1, 4); bd[i] = W'($urandom); pres[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstn             = ($urandom_range(0, 149) != 0);
      fifo_write_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pres[i] && $urandom_range(0, 2) == 0) pres[i] = 1;
        set_req(i, pres[i], rem[i] == 1, bd[i]);
      end
      e_rdy = m_busy ? (N'(fifo_write_ready) << m_owner) : N'(0);
      e_wen = m_busy && req_valid[m_owner] && fifo_write_ready;
      e_dat = exp_word(m_owner, bd[m_owner]);
      #1;
      n_checks++;
      if ({busy, grant_id, fifo_write_en, req_ready} !== {m_busy, IDW'(m_owner), e_wen, e_rdy}) begin
        n_fail++;
        $display("FAIL random c%0d busy/gid/wen/rdy got %b want %b", c,
                 {busy, grant_id, fifo_write_en, req_ready}, {m_busy, IDW'(m_owner), e_wen, e_rdy});
      end
      if (e_wen) begin
        n_checks++;
        if (fifo_data !== e_dat) begin
          n_fail++;
          $display("FAIL random_data c%0d got %h want %h", c, fifo_data, e_dat);
        end
      end
      @(posedge clk);
      if (e_wen) begin
        rem[m_owner]  = (rem[m_owner] == 1) ? $urandom_range(1, 4) : rem[m_owner] - 1;
        bd[m_owner]   = W'($urandom);
        pres[m_owner] = 0;
      end
      if (!rstn) begin
        m_busy = 0; m_owner = 0; m_rr = 0;
      end else if (!m_busy) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!found && req_valid[j]) begin found = 1; m_busy = 1; m_owner = j; end
        end
      end else if (e_wen && req_last[m_owner]) begin
        m_busy = 0;
        m_rr   = (m_owner + 1) % N;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_gap_wrap();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
